demand_phase_scheduler: RTL and testbench



---
 rtl/demand_phase_scheduler.sv | 152 +++++++++++++++
 tb/tb_demand_phase_scheduler.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/demand_phase_scheduler.sv
// demand_phase_scheduler: request-driven round-robin signal controller for a
// 4-way junction. Detector requests are latched, the next pending approach
// after the current owner gets the green, and min/max green, yellow and
// all-red clearance are timed in ticks from a free-running prescaler.
module demand_phase_scheduler #(
  parameter int TICK_DIV  = 500,
  parameter int GREEN_MIN = 2000,
  parameter int GREEN_MAX = 25000,
  parameter int YELLOW_T  = 2000,
  parameter int ALLRED_T  = 1000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] req,
  output logic [3:0] red,
  output logic [3:0] yellow,
  output logic [3:0] green,
  output logic [1:0] active_dir,
  output logic       green_start,
  output logic [3:0] pending
);

  localparam int NUM_DIR = 4;
  localparam int TW      = $clog2(TICK_DIV);
  localparam int PCW     = $clog2(GREEN_MAX + YELLOW_T + ALLRED_T + 1);

  localparam logic [TW-1:0]  TICK_LAST = TW'(TICK_DIV - 1);
  localparam logic [PCW-1:0] GMIN_L    = PCW'(GREEN_MIN - 1);
  localparam logic [PCW-1:0] GMAX_L    = PCW'(GREEN_MAX - 1);
  localparam logic [PCW-1:0] YEL_L     = PCW'(YELLOW_T - 1);
  localparam logic [PCW-1:0] AR_L      = PCW'(ALLRED_T - 1);

  localparam logic [1:0] S_ALL_RED = 2'd0;
  localparam logic [1:0] S_GREEN   = 2'd1;
  localparam logic [1:0] S_YELLOW  = 2'd2;

  logic [TW-1:0]  tick_cnt_q, tick_cnt_d;
  logic [1:0]     state_q, state_d;
  logic [PCW-1:0] phase_cnt_q, phase_cnt_d;
  logic [1:0]     active_dir_q, active_dir_d;
  logic [3:0]     pending_q, pending_d;
  logic           green_start_q, green_start_d;

  logic           tick;
  logic [3:0]     others;
  logic [1:0]     next_pick;
  logic [1:0]     cand;
  logic           found;

  // Free-running prescaler; never realigned to phase changes.
  always_comb begin
    tick       = (tick_cnt_q == TICK_LAST);
    tick_cnt_d = tick ? '0 : tick_cnt_q + 1'b1;
  end

  // Round-robin pick: first pending approach after the owner, owner last.
  always_comb begin
    others    = pending_q & ~(4'b0001 << active_dir_q);
    next_pick = active_dir_q;
    found     = 1'b0;
    cand      = active_dir_q;
    for (int k = 1; k <= NUM_DIR; k++) begin
      cand = active_dir_q + 2'(k);
      if (!found && pending_q[cand]) begin
        next_pick = cand;
        found     = 1'b1;
      end
    end
  end

  // Phase FSM, advancing only on tick; phase_cnt restarts on every entry.
  always_comb begin
    state_d      = state_q;
    phase_cnt_d  = phase_cnt_q;
    active_dir_d = active_dir_q;
    if (tick) begin
      case (state_q)
        S_ALL_RED: begin
          if (phase_cnt_q != AR_L) begin
            phase_cnt_d = phase_cnt_q + 1'b1;
          end else if (|pending_q) begin
            state_d      = S_GREEN;
            active_dir_d = next_pick;
            phase_cnt_d  = '0;
          end
        end
        S_GREEN: begin
          // Gap-out once min is served, or forced out at max, only if
          // someone else is waiting; otherwise rest in green.
          if (phase_cnt_q >= GMIN_L && |others &&
              (!req[active_dir_q] || phase_cnt_q == GMAX_L)) begin
            state_d     = S_YELLOW;
            phase_cnt_d = '0;
          end else if (phase_cnt_q != GMAX_L) begin
            phase_cnt_d = phase_cnt_q + 1'b1;
          end
        end
        S_YELLOW: begin
          if (phase_cnt_q == YEL_L) begin
            state_d     = S_ALL_RED;
            phase_cnt_d = '0;
          end else begin
            phase_cnt_d = phase_cnt_q + 1'b1;
          end
        end
        default: begin
          state_d     = S_ALL_RED;
          phase_cnt_d = '0;
        end
      endcase
    end
  end

  // Request latch; the green owner's flag is held clear for its whole green,
  // including the first cycle, so clearing keys off the next state.
  always_comb begin
    pending_d     = pending_q | req;
    if (state_d == S_GREEN) pending_d[active_dir_d] = 1'b0;
    green_start_d = (state_d == S_GREEN) && (state_q != S_GREEN);
  end

  // State registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tick_cnt_q    <= '0;
      state_q       <= S_ALL_RED;
      phase_cnt_q   <= '0;
      active_dir_q  <= 2'd0;
      pending_q     <= 4'b0000;
      green_start_q <= 1'b0;
    end else begin
      tick_cnt_q    <= tick_cnt_d;
      state_q       <= state_d;
      phase_cnt_q   <= phase_cnt_d;
      active_dir_q  <= active_dir_d;
      pending_q     <= pending_d;
      green_start_q <= green_start_d;
    end
  end

  // Per-approach lamp decode from registered state only.
  for (genvar i = 0; i < NUM_DIR; i++) begin : g_lamp
    assign green[i]  = (state_q == S_GREEN)  && (active_dir_q == 2'(i));
    assign yellow[i] = (state_q == S_YELLOW) && (active_dir_q == 2'(i));
    assign red[i]    = !(green[i] || yellow[i]);
  end

  assign active_dir  = active_dir_q;
  assign pending     = pending_q;
  assign green_start = green_start_q;

endmodule

// File: tb/tb_demand_phase_scheduler.sv
// Randomized scoreboard bench for demand_phase_scheduler: a tick-level
// behavioural model predicts every cycle's lamps/flags; a monitor compares.
module tb_demand_phase_scheduler;

  localparam int TD   = 4;
  localparam int GMIN = 3;
  localparam int GMAX = 6;
  localparam int YT   = 2;
  localparam int ART  = 1;

  localparam int AR = 0, GR = 1, YE = 2;

  typedef struct packed {
    logic [3:0] red;
    logic [3:0] yel;
    logic [3:0] grn;
    logic [1:0] dir;
    logic       gs;
    logic [3:0] pend;
  } obs_t;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] req;
  logic [3:0] red, yellow, green, pending;
  logic [1:0] active_dir;
  logic       green_start;

  int n_chk  = 0;
  int n_pass = 0;
  obs_t exp_q[$];

  // model state
  int       m_cyc, m_ph, m_el, m_dir;
  bit [3:0] m_pend;
  bit       m_gs;

  demand_phase_scheduler #(
    .TICK_DIV(TD), .GREEN_MIN(GMIN), .GREEN_MAX(GMAX),
    .YELLOW_T(YT), .ALLRED_T(ART)
  ) dut (
    .clk(clk), .reset(reset), .req(req),
    .red(red), .yellow(yellow), .green(green),
    .active_dir(active_dir), .green_start(green_start), .pending(pending)
  );

  always #5 clk = ~clk;

  function automatic obs_t cur_obs();
    return {red, yellow, green, active_dir, green_start, pending};
  endfunction

  function automatic obs_t reset_obs();
    return {4'b1111, 4'b0000, 4'b0000, 2'd0, 1'b0, 4'b0000};
  endfunction

  task automatic chk(input string name, input obs_t act, input obs_t exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s @%0t: got red=%b yel=%b grn=%b dir=%0d gs=%b pend=%b, want red=%b yel=%b grn=%b dir=%0d gs=%b pend=%b",
                  name, $time, act.red, act.yel, act.grn, act.dir, act.gs, act.pend,
                  exp.red, exp.yel, exp.grn, exp.dir, exp.gs, exp.pend);
  endtask

  task automatic model_reset();
    m_cyc = 0; m_ph = AR; m_el = 0; m_dir = 0; m_pend = '0; m_gs = 0;
  endtask

  // Advance the model across one clock edge with request r, push expectation.
  task automatic model_step(input bit [3:0] r);
    bit       tick;
    bit       others;
    bit       found;
    int       nph, ndir, d;
    bit [3:0] np;
    obs_t     e;
    tick   = (m_cyc % TD) == TD - 1;
    nph    = m_ph;
    ndir   = m_dir;
    np     = m_pend | r;
    others = 0;
    for (int i = 0; i < 4; i++) if (i != m_dir && m_pend[i]) others = 1;
    if (tick) begin
      if (m_ph == AR) begin
        if (m_el >= ART - 1 && m_pend != 0) begin
          found = 0;
          for (int k = 1; k <= 4; k++) begin
            d = (m_dir + k) % 4;
            if (!found && m_pend[d]) begin ndir = d; found = 1; end
          end
          nph = GR;
        end
      end else if (m_ph == GR) begin
        if (m_el >= GMIN - 1 && others && (!r[m_dir] || m_el >= GMAX - 1)) nph = YE;
      end else begin
        if (m_el >= YT - 1) nph = AR;
      end
    end
    m_gs = (nph == GR) && (m_ph != GR);
    if (nph != m_ph) m_el = 0;
    else if (tick)   m_el++;
    if (nph == GR) np[ndir] = 1'b0;
    m_ph = nph; m_dir = ndir; m_pend = np; m_cyc++;
    for (int i = 0; i < 4; i++) begin
      e.grn[i] = (m_ph == GR) && (i == m_dir);
      e.yel[i] = (m_ph == YE) && (i == m_dir);
      e.red[i] = !(e.grn[i] || e.yel[i]);
    end
    e.dir  = 2'(m_dir);
    e.gs   = m_gs;
    e.pend = m_pend;
    exp_q.push_back(e);
  endtask

  // Drive at a negedge, predict the coming edge, return at the next negedge.
  task automatic cycle(input bit [3:0] r);
    req = r;
    model_step(r);
    @(negedge clk);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    req   = '0;
    repeat (2) @(negedge clk);
    chk("reset_hold", cur_obs(), reset_obs());
    reset = 1'b0;
    exp_q.delete();
    model_reset();
  endtask

  // Monitor: compare one expectation per post-edge sample.
  initial begin
    obs_t e;
    forever begin
      @(posedge clk);
      #1;
      if (!reset && exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("cycle", cur_obs(), e);
      end
    end
  end

  initial begin
    bit [3:0] held;
    int guard;
    reset = 1'b1;
    req   = '0;
    model_reset();
    @(negedge clk);
    do_reset();

    // idle: all red, no green_start
    repeat (200) cycle(4'b0000);

    // single S request, then rest in green
    cycle(4'b0100);
    repeat (200) cycle(4'b0000);

    // N green with req[0] held, E pulsed: max-out path
    do_reset();
    cycle(4'b0001);
    guard = 0;
    while (m_ph != GR && guard < 100) begin cycle(4'b0001); guard++; end
    if (guard >= 100) chk("reach_green_n", cur_obs(), ~cur_obs());
    cycle(4'b0011);
    repeat (80) cycle(4'b0001);

    // N green, req[0] low, S and W pending: gap-out and rotation
    do_reset();
    repeat (8) cycle(4'b0001);
    cycle(4'b1100);
    repeat (120) cycle(4'b0000);

    // all requests held: full rotation at max green
    repeat (300) cycle(4'b1111);

    // sparse random pulses
    repeat (600) cycle({$urandom_range(15) == 0, $urandom_range(15) == 0,
                        $urandom_range(15) == 0, $urandom_range(15) == 0});

    // slowly changing random levels
    held = '0;
    for (int i = 0; i < 600; i++) begin
      if (i % 32 == 0) held = 4'($urandom_range(15));
      cycle(held);
    end

    // dense random
    repeat (400) cycle(4'($urandom));

    // asynchronous reset inside a yellow cycle
    guard = 0;
    while (m_ph != YE && guard < 200) begin cycle(4'b1111); guard++; end
    if (guard >= 200) chk("reach_yellow", cur_obs(), ~cur_obs());
    req = 4'b1111;
    model_step(4'b1111);
    @(posedge clk);
    #2;
    reset = 1'b1;
    #1;
    chk("async_reset", cur_obs(), reset_obs());
    do_reset();
    repeat (200) cycle(4'b0000);

    @(posedge clk);
    #2;
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
